lsu_unit: RTL and testbench

- Load/store unit directly downstream of the ALU in the RV32 datapath.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs a valid/ready transaction on the data-memory bus, then returns sign- or zero-extended load data to the writeback mux.
- Stalls the single-cycle core while the access is outstanding.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu_unit.sv | 123 ++++++++++++
 tb/tb_lsu_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32 load/store unit.
package lsu_pkg;

   // RV32 load/store funct3 encodings
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam int STRB_W = 4;

   typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} lsu_state_e;

   // Request captured when the core's access is accepted
   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   // Half needs off[0]=0, word needs off=00; bytes are always aligned
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         LH[1:0]: return off[0];
         LW[1:0]: return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   // Loads 011/110/111 and any store with funct3[2] set do not exist in RV32
   function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
      return we ? funct3[2] : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
   endfunction

   // Force the low address bits to the natural alignment of the access size
   function automatic logic [1:0] align_off(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         SB[1:0]: return off;
         SH[1:0]: return {off[1], 1'b0};
         SW[1:0]: return 2'b00;
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering. STORE=1: replicate store data and build byte strobes.
// STORE=0: pick the addressed byte/half out of a read word and extend it;
// strobes are always zero in this mode so both instances share one port list.
module lsu_align
   import lsu_pkg::*;
#(
   parameter bit STORE = 1'b1
) (
   input  logic [2:0]        funct3,
   input  logic [1:0]        off,
   input  logic [31:0]       din,
   output logic [31:0]       dout,
   output logic [STRB_W-1:0] strb
);

   logic [31:0] shifted;
   logic [7:0]  b;
   logic [15:0] h;
   logic        sx;

   // Lane select / replicate and extend according to access size
   always_comb begin
      dout    = '0;
      strb    = '0;
      shifted = din >> {off, 3'b000};
      b       = shifted[7:0];
      h       = off[1] ? din[31:16] : din[15:0];
      sx      = ~funct3[2];
      if (STORE) begin
         case (funct3)
            SB: begin
               dout = {4{din[7:0]}};
               strb = 4'b0001 << off;
            end
            SH: begin
               dout = {2{din[15:0]}};
               strb = 4'b0011 << off;
            end
            default: begin
               dout = din;
               strb = 4'b1111;
            end
         endcase
      end else begin
         case (funct3)
            LB, LBU: dout = {{24{sx & b[7]}}, b};
            LH, LHU: dout = {{16{sx & h[15]}}, h};
            default: dout = din;
         endcase
      end
   end

endmodule

// File: rtl/lsu_unit.sv
// RV32 load/store unit: one valid/ready beat per core access, stalls the
// core until completion, optional bus timeout (TIMEOUT_CYCLES=0 disables it).
// Build option MISALIGN_EXC_EN: misaligned accesses fault instead of being
// silently rounded down to natural alignment.
module lsu_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        lsu_valid,
   input  logic        lsu_we,
   input  logic [2:0]  lsu_funct3,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic [31:0] lsu_rdata,
   output logic        lsu_done,
   output logic        lsu_stall,
   output logic        lsu_err,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   lsu_state_e        state;
   lsu_req_t          req;
   logic [CW-1:0]     cnt;
   logic [31:0]       rdata_q;
   logic              done_q, err_q;
   logic              in_bus, bad_req;
   logic [31:0]       st_data, ld_data;
   logic [STRB_W-1:0] st_strb, ld_strb;

   lsu_align #(.STORE(1'b1)) u_st (
      .funct3 (req.funct3),
      .off    (req.addr[1:0]),
      .din    (req.wdata),
      .dout   (st_data),
      .strb   (st_strb)
   );

   lsu_align #(.STORE(1'b0)) u_ld (
      .funct3 (req.funct3),
      .off    (req.addr[1:0]),
      .din    (mem_rdata),
      .dout   (ld_data),
      .strb   (ld_strb)
   );

   // Requests that fault before touching the bus
`ifdef MISALIGN_EXC_EN
   assign bad_req = is_illegal(lsu_we, lsu_funct3) | is_misaligned(lsu_funct3, lsu_addr[1:0]);
`else
   assign bad_req = is_illegal(lsu_we, lsu_funct3);
`endif

   // Access FSM, timeout counter and completion registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         req     <= '0;
         cnt     <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: if (lsu_valid) begin
               req.we     <= lsu_we;
               req.funct3 <= lsu_funct3;
               req.addr   <= {lsu_addr[31:2], align_off(lsu_funct3, lsu_addr[1:0])};
               req.wdata  <= lsu_wdata;
               cnt        <= '0;
               if (bad_req) begin
                  state  <= ERR;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end else begin
                  state <= BUS;
               end
            end
            BUS: begin
               // mem_ready takes priority over an expiring timeout
               if (mem_ready) begin
                  if (!req.we) rdata_q <= ld_data;
                  state  <= DONE;
                  done_q <= 1'b1;
               end else if (TIMEOUT_CYCLES != 0 && cnt == LIMIT) begin
                  state  <= ERR;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_bus    = (state == BUS);
   assign mem_valid = in_bus;
   assign mem_we    = in_bus & req.we;
   assign mem_addr  = in_bus ? {req.addr[31:2], 2'b00} : '0;
   assign mem_wdata = (in_bus & req.we) ? st_data : '0;
   assign mem_wstrb = (in_bus & req.we) ? (st_strb | ld_strb) : '0;

   assign lsu_done  = done_q;
   assign lsu_err   = err_q;
   assign lsu_rdata = err_q ? '0 : rdata_q;
   assign lsu_stall = lsu_valid & ~lsu_done;

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: directed cases plus random accesses, with
// expectations from an arithmetic reference model of the lane/timeout rules.
module tb_lsu_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        lsu_valid = 1'b0, lsu_we = 1'b0;
   logic [2:0]  lsu_funct3 = '0;
   logic [31:0] lsu_addr = '0, lsu_wdata = '0;
   logic [31:0] lsu_rdata;
   logic        lsu_done, lsu_stall, lsu_err;
   logic        mem_valid, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;

   lsu_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .lsu_valid(lsu_valid), .lsu_we(lsu_we),
      .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_stall(lsu_stall),
      .lsu_err(lsu_err), .mem_valid(mem_valid), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  strb;
      int          cycles;
   } beat_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   beat_t       bus_q[$];
   resp_t       resp_q[$];
   int          passed = 0, total = 0;
   int          rdy_delay = -1;
   logic [31:0] last_rd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   // Memory responder: raise mem_ready in BUS cycle number rdy_delay (0-based)
   initial begin
      int vcnt = 0;
      forever begin
         @(posedge clk); #1;
         if (reset || !mem_valid) begin
            mem_ready = 1'b0;
            vcnt = 0;
         end else begin
            mem_ready = (rdy_delay >= 0 && vcnt == rdy_delay);
            vcnt++;
         end
      end
   end

   // Monitor: compare bus beats and completions against the scoreboard queues
   initial begin
      int beat_cycles = 0;
      beat_t b;
      resp_t r;
      forever begin
         @(negedge clk);
         if (reset) begin
            beat_cycles = 0;
         end else begin
            if (mem_valid) begin
               beat_cycles++;
               if (bus_q.size() == 0) chk("no_beat_expected", {31'd0, mem_valid}, 32'd0);
               else begin
                  b = bus_q[0];
                  chk("mem_addr", mem_addr, b.addr);
                  chk("mem_we", {31'd0, mem_we}, {31'd0, b.we});
                  chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, b.strb});
                  if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
                  if (mem_ready) begin
                     chk("beat_len", beat_cycles, b.cycles);
                     void'(bus_q.pop_front());
                     beat_cycles = 0;
                  end
               end
            end else if (beat_cycles != 0) begin
               if (bus_q.size() != 0) begin
                  chk("beat_len", beat_cycles, bus_q[0].cycles);
                  void'(bus_q.pop_front());
               end
               beat_cycles = 0;
            end
            if (lsu_done) begin
               if (resp_q.size() == 0) chk("no_done_expected", {31'd0, lsu_done}, 32'd0);
               else begin
                  r = resp_q.pop_front();
                  chk("lsu_err", {31'd0, lsu_err}, {31'd0, r.err});
                  chk("lsu_rdata", lsu_rdata, r.rdata);
               end
            end
         end
      end
   end

   // Model the access, queue expectations, drive it and wait for lsu_done.
   // d = BUS cycle (0-based) in which mem_ready rises; negative = never.
   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int d);
      int          size, off, lat, n, stall_n;
      logic        ill, mis, bus, tmo;
      longint      lv, range;
      logic [31:0] ea;
      beat_t       b;
      resp_t       r;
      ill  = we ? f3[2] : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      mis  = (a % 32'(size)) != 0;
      ea   = a - (a % 32'(size));
`ifdef MISALIGN_EXC_EN
      bus = !ill && !mis;
`else
      bus = !ill;
`endif
      tmo  = bus && (d < 0 || d > 15);
      off  = int'(ea[1:0]);
      if (bus) begin
         b.addr   = ea - 32'(off);
         b.we     = we;
         b.cycles = tmo ? 16 : d + 1;
         b.strb   = we ? 4'(((1 << size) - 1) << off) : 4'b0;
         b.wdata  = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                    (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
         bus_q.push_back(b);
      end
      if (size == 4) lv = longint'(rd);
      else begin
         range = 64'd1 << (8 * size);
         lv = longint'(rd >> (8 * off)) % range;
         if (!f3[2] && lv >= range / 2) lv = lv - range;
      end
      r.err   = !bus || tmo;
      r.rdata = r.err ? 32'd0 : (we ? last_rd : 32'(lv));
      if (!r.err && !we) last_rd = 32'(lv);
      resp_q.push_back(r);
      lat = !bus ? 1 : (tmo ? 17 : d + 2);

      @(posedge clk); #1;
      rdy_delay  = d;
      mem_rdata  = rd;
      lsu_we     = we;
      lsu_funct3 = f3;
      lsu_addr   = a;
      lsu_wdata  = wd;
      lsu_valid  = 1'b1;
      n = 0;
      stall_n = 0;
      while (1) begin
         #1;
         if (lsu_stall) stall_n++;
         @(posedge clk); #1;
         n++;
         if (lsu_done || n > 40) break;
      end
      chk("done_latency", n, lat);
      chk("stall_cycles", stall_n, lat);
      chk("stall_in_done", {31'd0, lsu_stall}, 32'd0);
      lsu_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        rwe;
      logic [2:0]  rf3;
      int          rd_sel, dd;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_done", {31'd0, lsu_done}, 32'd0);
      chk("reset_err", {31'd0, lsu_err}, 32'd0);
      chk("reset_rdata", lsu_rdata, 32'd0);
      chk("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("reset_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
      reset = 1'b0;

      // Directed cases
      do_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);   // LW
      do_access(1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_1234, 0);   // LB
      do_access(1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_1234, 1);   // LBU
      do_access(1'b1, 3'b001, 32'h0000_0302, 32'h0000_ABCD, 32'h0, 3);   // SH
      do_access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1357_9BDF, 0);   // misaligned LW
      do_access(1'b0, 3'b001, 32'h0000_0103, 32'h0, 32'hF00D_8001, 0);   // misaligned LH
      do_access(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h1111_2222, -1);  // timeout
      do_access(1'b0, 3'b101, 32'h0000_0502, 32'h0, 32'h9ABC_0000, 15);  // ready at limit
      do_access(1'b0, 3'b011, 32'h0000_0600, 32'h0, 32'h0, 0);           // illegal load
      do_access(1'b1, 3'b100, 32'h0000_0600, 32'h1234_5678, 32'h0, 0);   // illegal store
      do_access(1'b1, 3'b000, 32'h0000_0701, 32'h0000_00A5, 32'h0, 2);   // SB

      // Reset in the middle of a bus beat
      do_access(1'b0, 3'b010, 32'h0000_0800, 32'h0, 32'h0, 0);
      bus_q.push_back('{addr: 32'h0000_0400, wdata: 32'h0, we: 1'b0, strb: 4'b0, cycles: 16});
      @(posedge clk); #1;
      rdy_delay  = -1;
      lsu_we     = 1'b0;
      lsu_funct3 = 3'b010;
      lsu_addr   = 32'h0000_0400;
      lsu_valid  = 1'b1;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_done", {31'd0, lsu_done}, 32'd0);
      chk("rst_err", {31'd0, lsu_err}, 32'd0);
      chk("rst_rdata", lsu_rdata, 32'd0);
      bus_q.delete();
      resp_q.delete();
      last_rd   = '0;
      lsu_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_no_done", {31'd0, lsu_done}, 32'd0);
      end
      do_access(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 1);

      // Random accesses
      for (int i = 0; i < 40; i++) begin
         rwe = 1'($urandom_range(0, 1));
         rd_sel = $urandom_range(0, 19);
         if (rd_sel == 0) rf3 = rwe ? 3'b101 : 3'b111;
         else if (rwe) rf3 = 3'($urandom_range(0, 2));
         else begin
            case ($urandom_range(0, 4))
               0: rf3 = 3'b000;
               1: rf3 = 3'b001;
               2: rf3 = 3'b010;
               3: rf3 = 3'b100;
               default: rf3 = 3'b101;
            endcase
         end
         case ($urandom_range(0, 9))
            7: dd = 15;
            8: dd = -1;
            9: dd = 16;
            default: dd = $urandom_range(0, 3);
         endcase
         do_access(rwe, rf3, $urandom, $urandom, $urandom, dd);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      chk("bus_q_drained", bus_q.size(), 32'd0);
      chk("resp_q_drained", resp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
